prog_mem_loader: RTL

Program-memory responder for the processor's instruction fetch port (pc, ram_read_en, data_in). It holds a 128x16 instruction store and is filled over a byte-wide valid/ready load stream, high byte first. On completion it pulses start to the processor, then serves fetches with one-cycle read latency. Addresses beyond the loaded program return a NOP word.

---
 rtl/prog_mem_loader.sv | 96 +++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - instruction store filled over a byte stream, then serving processor fetches
// Words arrive high byte first; fetches beyond the loaded program return NOP_WORD.
module prog_mem_loader #(
   parameter int                    DEPTH      = 128,
   parameter int                    ADDR_WIDTH = 7,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   input  logic                  load_last,
   output logic                  load_ready,
   input  logic                  reload,
   input  logic                  ram_read_en,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  start,
   output logic                  loading,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

   localparam logic [ADDR_WIDTH:0] FULL     = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_IDX = FULL - (ADDR_WIDTH+1)'(1);

   state_t                state, state_nxt;
   logic [7:0]            hi_byte;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  xfer, wr_en, done;

   assign load_ready = (state != RUN);
   assign loading    = (state != RUN);
   assign xfer       = load_valid && load_ready;

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      done      = 1'b0;
      case (state)
         LOAD_HI: if (xfer) state_nxt = LOAD_LO;
         LOAD_LO: begin
            if (xfer) begin
               wr_en = (word_count != FULL);
               // Program ends on load_last or when this word fills the store
               if (load_last || word_count >= LAST_IDX) begin
                  done      = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = LOAD_HI;
               end
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = LOAD_HI;
      endcase
      if (reload) begin
         state_nxt = LOAD_HI;
         wr_en     = 1'b0;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD_HI;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
         data_out   <= '0;
         start      <= 1'b0;
         hi_byte    <= '0;
      end else begin
         start <= done;
         if (reload) begin
            word_count <= '0;
            data_out   <= '0;
         end else begin
            if (state == LOAD_HI && xfer) hi_byte <= load_byte;
            if (wr_en) word_count <= word_count + (ADDR_WIDTH+1)'(1);
            if (state == RUN && ram_read_en)
               data_out <= ({1'b0, pc} < word_count) ? mem[pc] : NOP_WORD;
         end
      end
   end

   // Store is left unreset; word_count alone decides which entries are valid
   always_ff @(posedge clk) begin
      if (wr_en) mem[word_count[ADDR_WIDTH-1:0]] <= {hi_byte, load_byte};
   end

endmodule
